// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk resolved per stage,
// carry registered between stages, valid/ready handshake with global stall.
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && rst_n;

  for (genvar gk = 0; gk < STAGES; gk++) begin : g_stage
    localparam int unsigned K  = gk;
    localparam int unsigned RW = WIDTH - K * CW;   // operand bits not yet consumed
    localparam int unsigned DW = (K + 1) * CW;     // result bits resolved after this stage

    logic [RW-1:0] a_d;
    logic [RW-1:0] bb_d;
    logic          c_d;
    logic          v_d;
    logic [CW:0]   part;
    logic [DW-1:0] sum_d;
    logic          v_q;
    logic          c_q;
    logic [DW-1:0] sum_q;

    if (K == 0) begin : g_head
      assign a_d   = a;
      assign bb_d  = b ^ {WIDTH{sub}};
      assign c_d   = ci ^ sub;
      assign v_d   = in_valid;
      assign sum_d = part[CW-1:0];
    end else begin : g_body
      assign a_d   = g_stage[gk-1].g_fwd.a_q;
      assign bb_d  = g_stage[gk-1].g_fwd.bb_q;
      assign c_d   = g_stage[gk-1].c_q;
      assign v_d   = g_stage[gk-1].v_q;
      assign sum_d = {part[CW-1:0], g_stage[gk-1].sum_q};
    end

    assign part = {1'b0, a_d[CW-1:0]} + {1'b0, bb_d[CW-1:0]} + (CW+1)'(c_d);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_d;
        c_q   <= part[CW];
        sum_q <= sum_d;
      end
    end

    if (K < STAGES - 1) begin : g_fwd
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] bb_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q  <= '0;
          bb_q <= '0;
        end else if (advance) begin
          a_q  <= a_d[RW-1:CW];
          bb_q <= bb_d[RW-1:CW];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is recovered as a ^ bb ^ sum at that bit.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= a_d[CW-1] ^ bb_d[CW-1] ^ part[CW-1] ^ part[CW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign co        = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule
